// File: rtl/uart_tx_frac_if.sv
// Handshake, configuration and line signals between a byte source and the
// fractional-baud UART transmitter.
interface uart_tx_frac_if #(
   parameter int WIDTH = 8
);
   logic             cfg_wr_en;
   logic [WIDTH-1:0] cfg_base;
   logic [9:0]       cfg_mask;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             TX;
   logic             busy;
   logic             frame_done;

   modport master (
      output cfg_wr_en, cfg_base, cfg_mask, tx_data, tx_valid,
      input  tx_ready, TX, busy, frame_done
   );

   modport slave (
      input  cfg_wr_en, cfg_base, cfg_mask, tx_data, tx_valid,
      output tx_ready, TX, busy, frame_done
   );
endinterface

// File: rtl/uart_tx_frac.sv
// UART transmitter (8N1) whose bit i lasts base + mask[i] clocks, so a
// non-integer clock/baud ratio is approximated by mixing N and N+1 periods.
module uart_tx_frac #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] BASE_DEFAULT = 168,
   parameter logic [9:0]       MASK_DEFAULT = 10'h3DF
) (
   input logic            CLOCK,
   input logic            RESET,
   uart_tx_frac_if.slave  bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] baseCfg_q;
   logic [9:0]       maskCfg_q;
   logic [WIDTH-1:0] baseSh_q;
   logic [9:0]       maskSh_q;
   logic [7:0]       data_q;
   logic [3:0]       idx_q;
   logic [WIDTH:0]   cnt_q;
   logic             tx_q;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   logic [WIDTH-1:0] base_d;
   logic [3:0]       nextIdx;
   logic [15:0]      maskPad;
   logic             nextStretch;
   logic [WIDTH:0]   firstPeriod;
   logic [WIDTH:0]   nextPeriod;

   // Periods are formed one bit wider than the divisor so base + 1 never wraps.
   always_comb begin
      base_d      = (bus.cfg_base < WIDTH'(2)) ? WIDTH'(2) : bus.cfg_base;
      nextIdx     = idx_q + 4'd1;
      maskPad     = {6'b0, maskSh_q};
      nextStretch = maskPad[nextIdx];
      firstPeriod = {1'b0, baseCfg_q} + {{WIDTH{1'b0}}, maskCfg_q[0]};
      nextPeriod  = {1'b0, baseSh_q} + {{WIDTH{1'b0}}, nextStretch};
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         baseCfg_q <= BASE_DEFAULT;
         maskCfg_q <= MASK_DEFAULT;
      end else if (bus.cfg_wr_en) begin
         baseCfg_q <= base_d;
         maskCfg_q <= cfg_mask_passthru(bus.cfg_mask);
      end
   end

   function automatic logic [9:0] cfg_mask_passthru(input logic [9:0] m);
      return m;
   endfunction

   // The shifter refills with ones, so the ninth shift naturally yields the stop bit.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= IDLE;
         baseSh_q <= BASE_DEFAULT;
         maskSh_q <= MASK_DEFAULT;
         data_q   <= 8'h00;
         idx_q    <= 4'd0;
         cnt_q    <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               if (bus.tx_valid && ready_q) begin
                  data_q   <= bus.tx_data;
                  baseSh_q <= baseCfg_q;
                  maskSh_q <= maskCfg_q;
                  idx_q    <= 4'd0;
                  cnt_q    <= firstPeriod - {{WIDTH{1'b0}}, 1'b1};
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  ready_q  <= 1'b0;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               ready_q <= 1'b0;
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - {{WIDTH{1'b0}}, 1'b1};
               end else if (idx_q != 4'd9) begin
                  idx_q  <= nextIdx;
                  cnt_q  <= nextPeriod - {{WIDTH{1'b0}}, 1'b1};
                  tx_q   <= data_q[0];
                  data_q <= {1'b1, data_q[7:1]};
               end else begin
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready   = ready_q;
   assign bus.TX         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frac.sv
// Directed bench for uart_tx_frac: captures every TX sample of a frame and
// compares it with a waveform built from base, mask and data.
module tb_uart_tx_frac;

   logic clock = 1'b0;
   logic reset = 1'b1;

   uart_tx_frac_if #(.WIDTH(8)) bus ();

   uart_tx_frac #(
      .WIDTH(8),
      .BASE_DEFAULT(8'd168),
      .MASK_DEFAULT(10'h3DF)
   ) dut (
      .CLOCK (clock),
      .RESET (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int   checks   = 0;
   int   failures = 0;
   logic txLog[$];
   logic expLog[$];
   int   frameLen;
   bit   doneSeen;
   bit   readyLowOk;
   bit   busyOk;
   logic doneTx;
   logic doneReady;
   logic doneBusy;

   function automatic void buildExpected(input int base, input logic [9:0] mask, input logic [7:0] data);
      int eb;
      logic b;
      eb = (base < 2) ? 2 : base;
      expLog.delete();
      for (int i = 0; i < 10; i++) begin
         if (i == 0) b = 1'b0;
         else if (i == 9) b = 1'b1;
         else b = data[i-1];
         for (int k = 0; k < eb + int'(mask[i]); k++) expLog.push_back(b);
      end
   endfunction

   function automatic int waveErrors();
      int e = 0;
      int n;
      n = (txLog.size() > expLog.size()) ? txLog.size() : expLog.size();
      for (int i = 0; i < n; i++) begin
         if (i >= txLog.size() || i >= expLog.size()) e++;
         else if (txLog[i] !== expLog[i]) e++;
      end
      return e;
   endfunction

   task automatic writeCfg(input logic [7:0] b, input logic [9:0] m);
      @(negedge clock);
      bus.cfg_base  = b;
      bus.cfg_mask  = m;
      bus.cfg_wr_en = 1'b1;
      @(negedge clock);
      bus.cfg_wr_en = 1'b0;
   endtask

   // Offers a byte and returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input bit hold, input bit cfgSame,
                                input logic [7:0] cb, input logic [9:0] cm);
      int n = 0;
      @(negedge clock);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      while (bus.tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 5000) begin
         failures++;
         $display("[TB] FAIL accept_wait: tx_ready=%b after %0d cycles, required 1", bus.tx_ready, n);
      end
      if (cfgSame) begin
         bus.cfg_base  = cb;
         bus.cfg_mask  = cm;
         bus.cfg_wr_en = 1'b1;
      end
      @(posedge clock);
      #1;
      if (!hold) bus.tx_valid = 1'b0;
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic captureFrame(input int limit, input int cfgAt, input logic [7:0] cb, input logic [9:0] cm);
      txLog.delete();
      frameLen   = -1;
      doneSeen   = 1'b0;
      readyLowOk = 1'b1;
      busyOk     = 1'b1;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clock);
         bus.cfg_wr_en = 1'b0;
         if (n == cfgAt) begin
            bus.cfg_base  = cb;
            bus.cfg_mask  = cm;
            bus.cfg_wr_en = 1'b1;
         end
         if (bus.frame_done === 1'b1) begin
            frameLen  = n - 1;
            doneSeen  = 1'b1;
            doneTx    = bus.TX;
            doneReady = bus.tx_ready;
            doneBusy  = bus.busy;
            break;
         end
         txLog.push_back(bus.TX);
         if (bus.tx_ready !== 1'b0) readyLowOk = 1'b0;
         if (bus.busy !== 1'b1) busyOk = 1'b0;
      end
      checks++;
      if (!doneSeen) begin
         failures++;
         $display("[TB] FAIL frame_done_wait: no frame_done within %0d cycles, required a pulse", limit);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (bus.tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b required 0", bus.tx_ready); end
      checks++;
      if (bus.TX !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b required 1", bus.TX); end
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_busy_done: got busy=%b done=%b required 0 0", bus.busy, bus.frame_done);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready: got %b required 1", bus.tx_ready); end
   endtask

   task automatic test_defaults();
      int e;
      applyStimulus(8'h55, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(3000, 0, 8'h00, 10'h000);
      buildExpected(168, 10'h3DF, 8'h55);
      checks++;
      if (frameLen !== 1689) begin failures++; $display("[TB] FAIL default_len: got %0d required 1689", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL default_wave: %0d bad samples, required 0", e); end
      checks++;
      if (!readyLowOk || !busyOk) begin
         failures++; $display("[TB] FAIL default_flags: readyLow=%b busyHigh=%b required 1 1", readyLowOk, busyOk);
      end
      checks++;
      if (doneReady !== 1'b1 || doneBusy !== 1'b0) begin
         failures++; $display("[TB] FAIL default_end: ready=%b busy=%b required 1 0", doneReady, doneBusy);
      end
      @(negedge clock);
      checks++;
      if (bus.frame_done !== 1'b0 || bus.TX !== 1'b1) begin
         failures++; $display("[TB] FAIL default_pulse: done=%b tx=%b required 0 1", bus.frame_done, bus.TX);
      end
   endtask

   task automatic test_fast();
      int e;
      writeCfg(8'd4, 10'h000);
      applyStimulus(8'hA3, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(200, 0, 8'h00, 10'h000);
      buildExpected(4, 10'h000, 8'hA3);
      checks++;
      if (frameLen !== 40) begin failures++; $display("[TB] FAIL fast_len: got %0d required 40", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL fast_wave: %0d bad samples, required 0", e); end
   endtask

   task automatic test_cfg_midframe();
      int e;
      writeCfg(8'd168, 10'h3DF);
      applyStimulus(8'h3C, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(3000, 700, 8'd4, 10'h200);
      buildExpected(168, 10'h3DF, 8'h3C);
      checks++;
      if (frameLen !== 1689) begin failures++; $display("[TB] FAIL mid_len: got %0d required 1689", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL mid_wave: %0d bad samples, required 0", e); end

      applyStimulus(8'h81, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(200, 0, 8'h00, 10'h000);
      buildExpected(4, 10'h200, 8'h81);
      checks++;
      if (frameLen !== 41) begin failures++; $display("[TB] FAIL next_len: got %0d required 41", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL next_wave: %0d bad samples, required 0", e); end

      applyStimulus(8'h0F, 1'b0, 1'b1, 8'd6, 10'h000);
      captureFrame(200, 0, 8'h00, 10'h000);
      buildExpected(4, 10'h200, 8'h0F);
      checks++;
      if (frameLen !== 41) begin failures++; $display("[TB] FAIL same_edge_len: got %0d required 41", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL same_edge_wave: %0d bad samples, required 0", e); end

      applyStimulus(8'hF0, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(200, 0, 8'h00, 10'h000);
      checks++;
      if (frameLen !== 60) begin failures++; $display("[TB] FAIL after_same_len: got %0d required 60", frameLen); end
   endtask

   task automatic test_back_to_back();
      int e;
      int dones = 0;
      writeCfg(8'd4, 10'h000);
      applyStimulus(8'h96, 1'b1, 1'b0, 8'h00, 10'h000);
      bus.tx_data = 8'h5A;
      captureFrame(200, 0, 8'h00, 10'h000);
      if (doneSeen) dones++;
      buildExpected(4, 10'h000, 8'h96);
      checks++;
      if (frameLen !== 40) begin failures++; $display("[TB] FAIL b2b_len1: got %0d required 40", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL b2b_wave1: %0d bad samples, required 0", e); end
      checks++;
      if (!readyLowOk || doneTx !== 1'b1 || doneReady !== 1'b1) begin
         failures++; $display("[TB] FAIL b2b_gap: readyLow=%b gapTx=%b gapReady=%b required 1 1 1", readyLowOk, doneTx, doneReady);
      end
      captureFrame(200, 0, 8'h00, 10'h000);
      bus.tx_valid = 1'b0;
      if (doneSeen) dones++;
      buildExpected(4, 10'h000, 8'h5A);
      checks++;
      if (frameLen !== 40) begin failures++; $display("[TB] FAIL b2b_len2: got %0d required 40", frameLen); end
      e = waveErrors();
      checks++;
      if (e !== 0) begin failures++; $display("[TB] FAIL b2b_wave2: %0d bad samples, required 0", e); end
      checks++;
      if (!readyLowOk || dones !== 2) begin
         failures++; $display("[TB] FAIL b2b_done: readyLow=%b pulses=%0d required 1 2", readyLowOk, dones);
      end
   endtask

   task automatic test_clamp();
      int e;
      writeCfg(8'd0, 10'h000);
      applyStimulus(8'h33, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(100, 0, 8'h00, 10'h000);
      buildExpected(0, 10'h000, 8'h33);
      e = waveErrors();
      checks++;
      if (frameLen !== 20 || e !== 0) begin
         failures++; $display("[TB] FAIL clamp0: len=%0d badSamples=%0d required 20 0", frameLen, e);
      end
      writeCfg(8'd1, 10'h000);
      applyStimulus(8'hCC, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(100, 0, 8'h00, 10'h000);
      buildExpected(1, 10'h000, 8'hCC);
      e = waveErrors();
      checks++;
      if (frameLen !== 20 || e !== 0) begin
         failures++; $display("[TB] FAIL clamp1: len=%0d badSamples=%0d required 20 0", frameLen, e);
      end
      writeCfg(8'hFF, 10'h3FF);
      applyStimulus(8'hC5, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(3000, 0, 8'h00, 10'h000);
      buildExpected(255, 10'h3FF, 8'hC5);
      e = waveErrors();
      checks++;
      if (frameLen !== 2560 || e !== 0) begin
         failures++; $display("[TB] FAIL max_base: len=%0d badSamples=%0d required 2560 0", frameLen, e);
      end
   endtask

   task automatic test_reset_midframe();
      int e;
      bit sawDone = 1'b0;
      writeCfg(8'd10, 10'h000);
      applyStimulus(8'hF7, 1'b0, 1'b0, 8'h00, 10'h000);
      repeat (43) @(negedge clock);
      checks++;
      if (bus.TX !== 1'b0) begin failures++; $display("[TB] FAIL abort_pre: tx=%b at data bit 3, required 0", bus.TX); end
      reset = 1'b1;
      @(negedge clock);
      if (bus.frame_done === 1'b1) sawDone = 1'b1;
      checks++;
      if (bus.TX !== 1'b1 || bus.busy !== 1'b0 || bus.tx_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_state: tx=%b busy=%b ready=%b required 1 0 0", bus.TX, bus.busy, bus.tx_ready);
      end
      @(negedge clock);
      if (bus.frame_done === 1'b1) sawDone = 1'b1;
      reset = 1'b0;
      @(negedge clock);
      if (bus.frame_done === 1'b1) sawDone = 1'b1;
      checks++;
      if (bus.tx_ready !== 1'b1 || sawDone) begin
         failures++; $display("[TB] FAIL abort_release: ready=%b sawDone=%b required 1 0", bus.tx_ready, sawDone);
      end
      applyStimulus(8'hF0, 1'b0, 1'b0, 8'h00, 10'h000);
      captureFrame(3000, 0, 8'h00, 10'h000);
      buildExpected(168, 10'h3DF, 8'hF0);
      e = waveErrors();
      checks++;
      if (frameLen !== 1689 || e !== 0) begin
         failures++; $display("[TB] FAIL abort_cfg_reset: len=%0d badSamples=%0d required 1689 0", frameLen, e);
      end
   endtask

   initial begin
      bus.cfg_wr_en = 1'b0;
      bus.cfg_base  = 8'h00;
      bus.cfg_mask  = 10'h000;
      bus.tx_data   = 8'h00;
      bus.tx_valid  = 1'b0;
      test_reset();
      test_defaults();
      test_fast();
      test_cfg_midframe();
      test_back_to_back();
      test_clamp();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
